// File: rtl/demux1x4_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux1x4_reg_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF  = 8;

   typedef enum logic [1:0] {
      SEL_A = 2'b00,
      SEL_B = 2'b01,
      SEL_C = 2'b10,
      SEL_D = 2'b11
   } sel_e;
endpackage

// File: rtl/demux1x4_reg_lane.sv
// One-entry holding register with valid/ready handshake, one per output lane.
module demux_lane
   import demux1x4_reg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   // A load in the same cycle as a drain keeps the lane full with the new word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer: routes an accepted word into the lane chosen by i_sel.
module demux1x4_reg
   import demux1x4_reg_pkg::*;
#(
   parameter int data_width = DATA_WIDTH_DEF,
   parameter int cnt_width  = CNT_WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [1:0]            i_sel,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [data_width-1:0] i_data,
   output logic [3:0]            o_valid,
   input  logic [3:0]            i_ready,
   output logic [data_width-1:0] o_data_a,
   output logic [data_width-1:0] o_data_b,
   output logic [data_width-1:0] o_data_c,
   output logic [data_width-1:0] o_data_d,
   output logic                  o_busy,
   output logic [cnt_width-1:0]  o_xfer_cnt
);

   logic [3:0]            w_valid;
   logic [3:0]            w_load;
   logic                  w_accept;
   logic [data_width-1:0] w_lane_data [4];
   logic [cnt_width-1:0]  r_xfer_cnt;

   // Readiness is per addressed lane only, so a stalled lane never blocks the others.
   assign o_ready  = !w_valid[i_sel] || i_ready[i_sel];
   assign w_accept = i_valid && o_ready;
   assign w_load   = w_accept ? (4'b0001 << i_sel) : 4'b0000;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      demux_lane #(
         .DATA_WIDTH (data_width)
      ) u_lane (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_load  (w_load[g]),
         .i_data  (i_data),
         .i_ready (i_ready[g]),
         .o_valid (w_valid[g]),
         .o_data  (w_lane_data[g])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_xfer_cnt <= '0;
      end else if (w_accept) begin
         r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
   end

   assign o_valid    = w_valid;
   assign o_busy     = |w_valid;
   assign o_xfer_cnt = r_xfer_cnt;
   assign o_data_a   = w_lane_data[SEL_A];
   assign o_data_b   = w_lane_data[SEL_B];
   assign o_data_c   = w_lane_data[SEL_C];
   assign o_data_d   = w_lane_data[SEL_D];

endmodule

// File: tb/tb_demux1x4_reg.sv
// Randomized and directed bench for demux1x4_reg against a lane-array reference model.
module tb_demux1x4_reg;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [1:0]  i_sel = 2'b00;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_data = '0;
   logic [3:0]  o_valid;
   logic [3:0]  i_ready = 4'b0000;
   logic [31:0] o_data_a, o_data_b, o_data_c, o_data_d;
   logic        o_busy;
   logic [7:0]  o_xfer_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: four lane slots and an accepted-word count
   logic [3:0]  m_valid;
   logic [31:0] m_data [4];
   int          m_cnt;

   demux1x4_reg dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_sel      (i_sel),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data_a   (o_data_a),
      .o_data_b   (o_data_b),
      .o_data_c   (o_data_c),
      .o_data_d   (o_data_d),
      .o_busy     (o_busy),
      .o_xfer_cnt (o_xfer_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_lane(input int k);
      case (k)
         0:       return o_data_a;
         1:       return o_data_b;
         2:       return o_data_c;
         default: return o_data_d;
      endcase
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_valid = 4'b0000;
         for (int k = 0; k < 4; k++) m_data[k] = '0;
         m_cnt = 0;
      end else begin
         automatic int  s   = int'(i_sel);
         automatic bit  acc = i_valid && (!m_valid[s] || i_ready[s]);
         for (int k = 0; k < 4; k++) begin
            if (acc && k == s) begin
               m_valid[k] = 1'b1;
               m_data[k]  = i_data;
            end else if (m_valid[k] && i_ready[k]) begin
               m_valid[k] = 1'b0;
            end
         end
         if (acc) m_cnt = (m_cnt + 1) % 256;
      end
   end

   always @(negedge i_clk) begin
      if (!i_rst) begin
         chk("ready", 64'(o_ready), 64'(!m_valid[i_sel] || i_ready[i_sel]));
         chk("valid", 64'(o_valid), 64'(m_valid));
         for (int k = 0; k < 4; k++) chk($sformatf("data_%0d", k), 64'(dut_lane(k)), 64'(m_data[k]));
         chk("busy", 64'(o_busy), 64'(m_valid != 4'b0000));
         chk("xfer_cnt", 64'(o_xfer_cnt), 64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
      i_valid = v;
      i_sel   = s;
      i_data  = d;
      i_ready = r;
   endtask

   task automatic do_reset();
      drive(0, 2'b00, '0, 4'b0000);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   initial begin
      tick();
      tick();
      i_rst = 1'b0;
      tick();

      // reset mid-traffic with lanes B and C full, no clock edge before checking
      drive(1, 2'b01, 32'hB0B0_0001, 4'b0000);
      tick();
      drive(1, 2'b10, 32'hC0C0_0002, 4'b0000);
      tick();
      drive(1, 2'b00, 32'h1234_5678, 4'b0000);
      chk("pre_rst_valid", 64'(o_valid), 64'h6);
      i_rst = 1'b1;
      #1;
      chk("rst_valid", 64'(o_valid), 64'h0);
      chk("rst_data_b", 64'(o_data_b), 64'h0);
      chk("rst_data_c", 64'(o_data_c), 64'h0);
      chk("rst_cnt", 64'(o_xfer_cnt), 64'h0);
      chk("rst_ready", 64'(o_ready), 64'h1);
      chk("rst_busy", 64'(o_busy), 64'h0);
      do_reset();

      // single route to lane C
      drive(1, 2'b10, 32'hDEAD_BEEF, 4'b0000);
      tick();
      drive(0, 2'b00, '0, 4'b0000);
      chk("route_valid", 64'(o_valid), 64'h4);
      chk("route_data_c", 64'(o_data_c), 64'hDEAD_BEEF);
      chk("route_cnt", 64'(o_xfer_cnt), 64'h1);

      // backpressure on A, then B still accepts
      do_reset();
      drive(1, 2'b00, 32'h1111_0000, 4'b0000);
      tick();
      drive(1, 2'b00, 32'h2222_0000, 4'b0000);
      #1;
      chk("bp_ready", 64'(o_ready), 64'h0);
      tick();
      chk("bp_data_a", 64'(o_data_a), 64'h1111_0000);
      chk("bp_cnt", 64'(o_xfer_cnt), 64'h1);
      i_sel = 2'b01;
      #1;
      chk("bp_ready_b", 64'(o_ready), 64'h1);
      tick();
      drive(0, 2'b00, '0, 4'b0000);
      chk("bp_valid_ab", 64'(o_valid), 64'h3);
      chk("bp_data_b", 64'(o_data_b), 64'h2222_0000);
      chk("bp_cnt2", 64'(o_xfer_cnt), 64'h2);

      // simultaneous load and drain on D at full rate
      do_reset();
      drive(1, 2'b11, 32'h0, 4'b0000);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'b11, 32'(5 + i), 4'b1000);
         #1;
         chk("ld_ready", 64'(o_ready), 64'h1);
         tick();
         chk("ld_valid_d", 64'(o_valid[3]), 64'h1);
         chk("ld_data_d", 64'(o_data_d), 64'(5 + i));
      end
      drive(0, 2'b00, '0, 4'b0000);
      chk("ld_cnt", 64'(o_xfer_cnt), 64'h5);

      // all four lanes drain together
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 2'(k), 32'hA000_0000 + 32'(k), 4'b0000);
         tick();
      end
      drive(0, 2'b00, '0, 4'b0000);
      chk("md_full", 64'(o_valid), 64'hF);
      i_ready = 4'b1111;
      tick();
      chk("md_valid", 64'(o_valid), 64'h0);
      chk("md_busy", 64'(o_busy), 64'h0);
      chk("md_data_b_kept", 64'(o_data_b), 64'hA000_0001);

      // counter wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1, 2'($urandom_range(0, 3)), $urandom, 4'b1111);
         tick();
      end
      drive(0, 2'b00, '0, 4'b1111);
      chk("wrap_cnt0", 64'(o_xfer_cnt), 64'h0);
      drive(1, 2'b01, 32'h257, 4'b1111);
      tick();
      drive(0, 2'b00, '0, 4'b0000);
      chk("wrap_cnt1", 64'(o_xfer_cnt), 64'h1);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
               4'($urandom_range(0, 15) & $urandom_range(0, 15)));
         if (($urandom_range(0, 7) == 0)) #2 i_sel = 2'($urandom_range(0, 3));
         tick();
      end
      drive(0, 2'b00, '0, 4'b0000);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
